// File: rtl/uart_tx.sv
// UART transmitter: a small byte FIFO feeding an LSB-first serialiser whose
// bit timing comes from an external baud clock sampled in the clk domain.
module uart_tx #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_UART,
  input  logic       en,
  input  logic [7:0] input_data,
  input  logic       input_valid,
  output logic       input_ready,
  output logic       tx,
  output logic       busy,
  output logic       output_done
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);
  localparam logic LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic ODD = (PARITY_ODD != 0);

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;

  logic [1:0]           buff;
  logic                 tick;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count;
  logic                 push, pop, empty, full;
  logic [DATA_BITS-1:0] head;
  state_t               state, state_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic [2:0]           bit_cnt, bit_cnt_n;
  logic                 stop_cnt, stop_cnt_n;
  logic                 parity_bit, parity_n;
  logic                 tx_n;
  logic                 load;

  // Rising edge of the baud clock yields a single-cycle tick two clks later.
  always_ff @(posedge clk) begin
    if (!reset) buff <= 2'b00;
    else        buff <= {buff[0], clk_UART};
  end
  assign tick = (buff == 2'b01);

  assign full        = (count == CW'(FIFO_DEPTH));
  assign empty       = (count == '0);
  assign input_ready = !full;
  assign push        = input_valid && input_ready;
  assign pop         = load;
  assign head        = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= input_data[DATA_BITS-1:0];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_IDLE;
      shift      <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
      parity_bit <= 1'b0;
      tx         <= 1'b1;
    end else begin
      state      <= state_n;
      shift      <= shift_n;
      bit_cnt    <= bit_cnt_n;
      stop_cnt   <= stop_cnt_n;
      parity_bit <= parity_n;
      tx         <= tx_n;
    end
  end

  // Parity is captured at load time because the shift register is consumed.
  always_comb begin
    state_n     = state;
    shift_n     = shift;
    bit_cnt_n   = bit_cnt;
    stop_cnt_n  = stop_cnt;
    parity_n    = parity_bit;
    tx_n        = tx;
    load        = 1'b0;
    output_done = 1'b0;
    if (tick) begin
      case (state)
        ST_IDLE: begin
          tx_n = 1'b1;
          if (en && !empty) load = 1'b1;
        end
        ST_START: begin
          tx_n      = shift[0];
          bit_cnt_n = '0;
          state_n   = ST_DATA;
        end
        ST_DATA: begin
          if (bit_cnt == LAST_BIT) begin
            if (PARITY_EN != 0) begin
              tx_n    = parity_bit;
              state_n = ST_PARITY;
            end else begin
              tx_n       = 1'b1;
              stop_cnt_n = 1'b0;
              state_n    = ST_STOP;
            end
          end else begin
            shift_n   = shift >> 1;
            tx_n      = shift[1];
            bit_cnt_n = bit_cnt + 1'b1;
          end
        end
        ST_PARITY: begin
          tx_n       = 1'b1;
          stop_cnt_n = 1'b0;
          state_n    = ST_STOP;
        end
        ST_STOP: begin
          if (stop_cnt == LAST_STOP) begin
            output_done = 1'b1;
            state_n     = ST_IDLE;
            if (en && !empty) load = 1'b1;
          end else begin
            stop_cnt_n = stop_cnt + 1'b1;
          end
        end
        default: state_n = ST_IDLE;
      endcase
      if (load) begin
        shift_n  = head;
        parity_n = ^head ^ ODD;
        tx_n     = 1'b0;
        state_n  = ST_START;
      end
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three configurations (8N1, 8E2, 8O1) share one stimulus
// stream; a UART-receiver monitor per instance checks frames against a scoreboard.
module tb_uart_tx;
  logic       clk = 1'b0;
  logic       reset;
  logic       clk_UART;
  logic       en;
  logic       input_valid;
  logic [7:0] input_data;
  logic [2:0] tx_w, busy_w, done_w, rdy_w;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  int         rx_cnt[3];
  bit         mon_en = 1'b0;
  bit         track = 1'b1;
  int         fill = 0;

  always #5 clk = ~clk;

  // Baud clock: 16 clk per bit period.
  initial begin
    clk_UART = 1'b0;
    forever begin
      repeat (8) @(posedge clk);
      #1 clk_UART = ~clk_UART;
    end
  end

  uart_tx #(.PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .reset(reset), .clk_UART(clk_UART), .en(en),
    .input_data(input_data), .input_valid(input_valid), .input_ready(rdy_w[0]),
    .tx(tx_w[0]), .busy(busy_w[0]), .output_done(done_w[0]));

  uart_tx #(.PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut1 (
    .clk(clk), .reset(reset), .clk_UART(clk_UART), .en(en),
    .input_data(input_data), .input_valid(input_valid), .input_ready(rdy_w[1]),
    .tx(tx_w[1]), .busy(busy_w[1]), .output_done(done_w[1]));

  uart_tx #(.PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut2 (
    .clk(clk), .reset(reset), .clk_UART(clk_UART), .en(en),
    .input_data(input_data), .input_valid(input_valid), .input_ready(rdy_w[2]),
    .tx(tx_w[2]), .busy(busy_w[2]), .output_done(done_w[2]));

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Line bits in transmission order, index 0 = start bit.
  function automatic logic [11:0] build_frame(input logic [7:0] b, input int pen, input int podd, input int nstop);
    int k;
    build_frame = '0;
    k = 1;
    for (int i = 0; i < 8; i++) begin
      build_frame[k] = b[i];
      k++;
    end
    if (pen != 0) begin
      build_frame[k] = 1'(($countones(b) % 2) ^ podd);
      k++;
    end
    for (int s = 0; s < nstop; s++) begin
      build_frame[k] = 1'b1;
      k++;
    end
  endfunction

  // Caller is #1 after a posedge; the byte is presented for exactly one edge.
  task automatic applyStimulus(input logic [7:0] b);
    bit accept;
    accept = (fill < 4);
    if (accept) begin
      fill++;
      if (track) exp_q.push_back(b);
    end
    input_data  = b;
    input_valid = 1'b1;
    @(posedge clk);
    #1 input_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (t < 6000 && !(busy_w == 3'b000 && rx_cnt[0] == exp_q.size() &&
           rx_cnt[1] == exp_q.size() && rx_cnt[2] == exp_q.size())) begin
      @(negedge clk);
      t++;
    end
    checkOutput("drain_complete", 32'(t < 6000), 32'd1);
    repeat (40) @(negedge clk);
    fill = 0;
  endtask

  for (genvar g = 0; g < 3; g++) begin : mon
    localparam int P_EN   = (g == 0) ? 0 : 1;
    localparam int P_ODD  = (g == 2) ? 1 : 0;
    localparam int N_STOP = (g == 1) ? 2 : 1;
    localparam int LEN    = 1 + 8 + P_EN + N_STOP;
    int dcnt;
    bit aborted;

    task automatic wait_clk(input int n);
      for (int k = 0; k < n; k++) begin
        @(negedge clk);
        if (done_w[g]) dcnt++;
        if (!mon_en) aborted = 1'b1;
      end
    endtask

    initial begin : run
      logic        prev;
      logic [11:0] frm;
      logic        busy_ok;
      int          early;
      rx_cnt[g] = 0;
      prev = 1'b1;
      forever begin
        @(negedge clk);
        if (mon_en && prev === 1'b1 && tx_w[g] === 1'b0) begin
          dcnt    = 0;
          aborted = 1'b0;
          busy_ok = 1'b1;
          frm     = '0;
          for (int j = 0; j < LEN; j++) begin
            wait_clk((j == 0) ? 7 : 16);
            frm[j]  = tx_w[g];
            busy_ok = busy_ok & busy_w[g];
          end
          early = dcnt;
          for (int k = 0; k < 12 && dcnt == 0; k++) wait_clk(1);
          if (!aborted) begin
            if (rx_cnt[g] >= exp_q.size()) begin
              checks++;
              errors++;
              $display("[TB] FAIL dut%0d_unexpected_frame: got frame 0x%0h, expected none", g, frm);
            end else begin
              checkOutput($sformatf("dut%0d_frame", g), 32'(frm),
                          32'(build_frame(exp_q[rx_cnt[g]], P_EN, P_ODD, N_STOP)));
              checkOutput($sformatf("dut%0d_busy_in_frame", g), 32'(busy_ok), 32'd1);
              checkOutput($sformatf("dut%0d_done_early", g), 32'(early), 32'd0);
              checkOutput($sformatf("dut%0d_done_count", g), 32'(dcnt), 32'd1);
            end
            rx_cnt[g]++;
          end
        end
        prev = tx_w[g];
      end
    end
  end

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int  t;
    int  gaps;
    bit  ok;
    reset       = 1'b0;
    en          = 1'b0;
    input_valid = 1'b0;
    input_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_tx", 32'(tx_w), 32'h7);
    checkOutput("reset_busy", 32'(busy_w), 32'h0);
    checkOutput("reset_ready", 32'(rdy_w), 32'h7);
    checkOutput("reset_done", 32'(done_w), 32'h0);
    reset  = 1'b1;
    mon_en = 1'b1;
    repeat (40) @(posedge clk);
    #1 checkOutput("idle_tx", 32'(tx_w), 32'h7);

    // Single 0x55 frame.
    en = 1'b1;
    applyStimulus(8'h55);
    drain();

    // Overflow with transmission disabled, then a back-to-back burst.
    en = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 1; i <= 4; i++) applyStimulus(8'(i));
    checkOutput("full_ready_low", 32'(rdy_w), 32'h0);
    applyStimulus(8'h05);
    checkOutput("full_ready_after_drop", 32'(rdy_w), 32'h0);
    repeat (50) @(posedge clk);
    #1 checkOutput("en_off_holds_line", 32'(tx_w), 32'h7);
    en = 1'b1;
    t = 0;
    while (busy_w[0] !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    gaps = 0;
    while (rx_cnt[0] < exp_q.size() && t < 4000) begin
      @(negedge clk);
      t++;
      if (!busy_w[0]) gaps++;
    end
    checkOutput("b2b_no_idle_gap", 32'(gaps), 32'd0);
    drain();

    // Parity corner bytes.
    @(posedge clk);
    #1;
    applyStimulus(8'h07);
    applyStimulus(8'h03);
    applyStimulus(8'h00);
    applyStimulus(8'hFF);
    drain();

    // Random bursts.
    for (int b = 0; b < 8; b++) begin
      int n;
      n = $urandom_range(4, 1);
      @(posedge clk);
      #1;
      for (int i = 0; i < n; i++) applyStimulus(8'($urandom_range(255, 0)));
      drain();
    end

    // en dropped during data bit 2 of the first of two queued bytes.
    @(posedge clk);
    #1;
    applyStimulus(8'hC3);
    applyStimulus(8'h3C);
    t = 0;
    while (tx_w[0] !== 1'b0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    checkOutput("edrop_first_start", 32'(t < 100), 32'd1);
    repeat (7 + 48) @(negedge clk);
    en = 1'b0;
    repeat (300) @(negedge clk);
    checkOutput("edrop_line_idle", 32'(tx_w), 32'h7);
    checkOutput("edrop_not_busy", 32'(busy_w), 32'h0);
    checkOutput("edrop_first_received", 32'(rx_cnt[0]), 32'(exp_q.size() - 1));
    @(posedge clk);
    #1 en = 1'b1;
    t = 0;
    while (tx_w[0] !== 1'b0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    checkOutput("edrop_restart_next_tick", 32'(t < 20), 32'd1);
    drain();

    // Write landing in the same clk as an idle tick.
    @(posedge clk_UART);
    @(posedge clk);
    #1;
    applyStimulus(8'h96);
    repeat (8) @(posedge clk);
    #1;
    checkOutput("tickwrite_no_start", 32'(tx_w), 32'h7);
    checkOutput("tickwrite_not_busy", 32'(busy_w), 32'h0);
    repeat (16) @(posedge clk);
    #1 checkOutput("tickwrite_start_bit", 32'(tx_w), 32'h0);
    drain();

    // Reset during data bit 3 of 0xA5.
    mon_en = 1'b0;
    track  = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(8'hA5);
    t = 0;
    while (tx_w[0] !== 1'b0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    checkOutput("reset_test_start", 32'(t < 100), 32'd1);
    repeat (7 + 64) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midframe_reset_tx", 32'(tx_w), 32'h7);
    checkOutput("midframe_reset_busy", 32'(busy_w), 32'h0);
    checkOutput("midframe_reset_ready", 32'(rdy_w), 32'h7);
    reset = 1'b1;
    ok = 1'b1;
    repeat (320) begin
      @(negedge clk);
      if (tx_w !== 3'b111 || busy_w !== 3'b000) ok = 1'b0;
    end
    checkOutput("post_reset_quiet", 32'(ok), 32'd1);
    fill   = 0;
    track  = 1'b1;
    mon_en = 1'b1;

    @(posedge clk);
    #1;
    applyStimulus(8'h5A);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
